// File: rtl/lfsr_pkg.sv
// Shared types, constants and the step function for the programmable LFSR.
// The step function is generic up to LFSR_MAX_W bits and is truncated by callers.
package lfsr_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned LFSR_MAX_W  = 64;

    localparam logic [7:0] POLY8_MAX = 8'hB8;
    localparam logic [3:0] POLY4_MAX = 4'hC;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } lfsr_phase_e;

    // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
    // Returns the raw shifted value; zero recovery is left to the caller.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] keep;
        fb   = ^(state & poly);
        keep = (64'd1 << width) - 64'd1;
        return ({state[LFSR_MAX_W-2:0], fb}) & keep;
    endfunction

endpackage

// File: rtl/lfsr_if.sv
// Pattern-generator control/data bundle: step enable, taps, seed and pattern out.
interface lfsr_if
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic             en;
    logic [WIDTH-1:0] poly;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] out;

    modport master (output en, output poly, output seed, input  out);
    modport slave  (input  en, input  poly, input  seed, output out);
endinterface

// File: rtl/lfsr_feedback.sv
// Combinational feedback network: next shifted value from current state and tap mask.
module lfsr_feedback
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = WIDTH'(lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(poly), WIDTH));
    end

endmodule

// File: rtl/lfsr.sv
// Programmable LFSR pattern generator: seed load on first enabled edge, then
// Fibonacci stepping with zero-state recovery. Output comes straight from the flops.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic  clock,
    input  logic  rst,
    lfsr_if.slave bus
);

    lfsr_phase_e      phase_q, phase_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] shifted;

    lfsr_feedback #(.WIDTH(WIDTH)) u_feedback (
        .state (state_q),
        .poly  (bus.poly),
        .next  (shifted)
    );

    always_comb begin
        phase_d = phase_q;
        state_d = state_q;
        if (bus.en) begin
            unique case (phase_q)
                ST_LOAD: begin
                    // A zero seed would lock the register up, so it loads 1 instead.
                    state_d = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
                    phase_d = ST_RUN;
                end
                ST_RUN: begin
                    state_d = (shifted == '0) ? WIDTH'(1) : shifted;
                end
                default: begin
                    phase_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            phase_q <= ST_LOAD;
            state_q <= '0;
        end else begin
            phase_q <= phase_d;
            state_q <= state_d;
        end
    end

    assign bus.out = state_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed + randomized bench for lfsr, checked against an arithmetic reference model.
module tb_lfsr;
    import lfsr_pkg::*;

    localparam int unsigned W = 8;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    lfsr_if #(.WIDTH(W)) bus ();

    lfsr #(.WIDTH(W)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] m_state     = 8'h00;
    bit         m_seeded    = 1'b0;

    // Reference step: double the value modulo 256 and add the parity of the tapped bits.
    function automatic logic [7:0] ref_step(input logic [7:0] cur, input logic [7:0] taps);
        int ones;
        int v;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (cur[i] && taps[i]) ones++;
        end
        v = (int'(cur) * 2 + (ones % 2)) % 256;
        if (v == 0) v = 1;
        return 8'(v);
    endfunction

    task automatic check_out(input string tag, input logic [7:0] exp);
        vectors++;
        assert (bus.out === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, bus.out, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        if (rst && bus.en) begin
            if (!m_seeded) begin
                m_state  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                m_seeded = 1'b1;
            end else begin
                m_state = ref_step(m_state, bus.poly);
            end
        end
        #1;
        check_out(tag, m_state);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases.
    task automatic pulse_reset(input string tag);
        #1;
        rst      = 1'b0;
        m_state  = 8'h00;
        m_seeded = 1'b0;
        #1;
        check_out(tag, 8'h00);
        #2;
        rst = 1'b1;
    endtask

    bit seen [256];
    int dups;
    int zeros;

    initial begin
        bus.en   = 1'b0;
        bus.poly = POLY8_MAX;
        bus.seed = 8'h01;

        // Reset state and basic load/shift sequence
        #2;
        check_out("reset_hold", 8'h00);
        #5;
        rst    = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) tick("load_seq");

        // Hold while disabled, then resume
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) tick("hold");
        bus.en = 1'b1;
        tick("resume");

        // Full period from A5 with the maximal polynomial
        bus.seed = 8'hA5;
        pulse_reset("reset_period");
        tick("period_load");
        foreach (seen[i]) seen[i] = 1'b0;
        dups  = 0;
        zeros = 0;
        for (int i = 0; i < 255; i++) begin
            tick("period_step");
            if (bus.out == 8'h00) zeros++;
            if (seen[bus.out]) dups++;
            seen[bus.out] = 1'b1;
        end
        check_out("period_return", 8'hA5);
        check_val("period_dups", dups, 0);
        check_val("period_zeros", zeros, 0);

        // Zero seed and zero polynomial handling
        bus.seed = 8'h00;
        pulse_reset("reset_zero_seed");
        tick("zero_seed_load");
        check_out("zero_seed_is_one", 8'h01);
        bus.poly = 8'h00;
        for (int i = 0; i < 8; i++) tick("poly_zero_walk");
        check_out("poly_zero_recover", 8'h01);

        // Mid-run reset reloads the seed present at release
        bus.poly = POLY8_MAX;
        for (int i = 0; i < 4; i++) tick("pre_midreset");
        bus.seed = 8'h3C;
        pulse_reset("midrun_reset_clear");
        tick("midrun_reload");
        check_out("midrun_reload_seed", 8'h3C);

        // Live polynomial change
        for (int i = 0; i < 3; i++) tick("pre_polychange");
        bus.poly = 8'h8E;
        for (int i = 0; i < 4; i++) tick("poly_8e");

        // Seed changes after seeding are ignored
        bus.seed = 8'hFF;
        for (int i = 0; i < 3; i++) tick("seed_ignored");

        // Randomized enables, taps, seeds and occasional resets
        for (int i = 0; i < 400; i++) begin
            bus.en   = ($urandom_range(0, 3) != 0);
            bus.seed = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.poly = 8'($urandom);
            if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
            tick("rand_step");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
